pc_gen: RTL and testbench

//   Program-counter stage directly upstream of the instruction-memory fetch stage.

---
 rtl/pc_gen.sv | 162 ++++++++++++++++
 tb/tb_pc_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen -- program-counter stage feeding the instruction-memory fetch stage.
//
// Drives the fetch address every cycle: sequential PC+4, hold on stall, or
// redirect on branch/jump from EX. A one-cycle alignment pipe delays PC and
// valid so they line up with the registered instruction word out of fetch.
// Misaligned redirect targets trap to TRAP_ADDR. A fetch address at or beyond
// the end of instruction memory stops the stage until reset.
//
// Ports
//   clk              in   1   clock, rising edge
//   rst              in   1   synchronous active-high reset
//   stall            in   1   hold PC, no new fetch
//   redirect_valid   in   1   branch taken / jump from EX
//   redirect_target  in   32  new PC when redirect_valid=1
//   pc_out           out  32  fetch address to instruction memory
//   pc_plus4         out  32  pc_out + 4 (link value), combinational
//   fetch_valid      out  1   pc_out is a real fetch this cycle
//   pc_d1            out  32  PC of the instruction word out of fetch this cycle
//   inst_valid       out  1   instruction word out of fetch is valid
//   trap             out  1   one-cycle pulse on a misaligned redirect
//   trap_badaddr     out  32  offending redirect target, held until next trap
//   halted           out  1   PC ran past the end of memory; sticky until rst
//   fetch_count      out  32  cycles with fetch_valid=1 and stall=0 (wraps)
// -----------------------------------------------------------------------------
module pc_gen #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] TRAP_ADDR  = 32'h0000_0100,
  parameter int unsigned IMEM_WORDS = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic [31:0] pc_d1,
  output logic        inst_valid,
  output logic        trap,
  output logic [31:0] trap_badaddr,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // One past the last legal byte address; 33 bits so the compare cannot wrap.
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) << 2;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pc_d1;
  logic        r_inst_valid;
  logic        r_trap;
  logic [31:0] r_badaddr;
  logic [31:0] r_count;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pc_d1_nxt;
  logic        w_inst_valid_nxt;
  logic        w_trap_nxt;
  logic [31:0] w_badaddr_nxt;
  logic [31:0] w_count_nxt;
  logic        w_misaligned;
  logic [31:0] w_pc_sel;

  assign w_misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);

  // Next PC in RUN, highest priority first: trap, redirect, stall, increment.
  always_comb begin
    if (w_misaligned)        w_pc_sel = TRAP_ADDR;
    else if (redirect_valid) w_pc_sel = redirect_target;
    else if (stall)          w_pc_sel = r_pc;
    else                     w_pc_sel = r_pc + 32'd4;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_pc_d1_nxt      = r_pc_d1;
    w_inst_valid_nxt = r_inst_valid;
    w_trap_nxt       = 1'b0;
    w_badaddr_nxt    = r_badaddr;
    w_count_nxt      = r_count;

    unique case (r_state)
      ST_BOOT: begin
        // Single settling cycle; stall/redirect are ignored here.
        w_state_nxt      = ST_RUN;
        w_pc_d1_nxt      = r_pc;
        w_inst_valid_nxt = 1'b0;
      end

      ST_RUN: begin
        w_pc_nxt = w_pc_sel;
        if (w_misaligned) begin
          w_trap_nxt    = 1'b1;
          w_badaddr_nxt = redirect_target;
        end
        // A stall without redirect freezes the word sitting in fetch; a
        // redirect flushes the word fetched this cycle.
        if (!stall || redirect_valid) begin
          w_pc_d1_nxt      = r_pc;
          w_inst_valid_nxt = !redirect_valid;
        end
        if (!stall) w_count_nxt = r_count + 32'd1;
        if ({1'b0, w_pc_sel} >= PC_LIMIT) w_state_nxt = ST_HALT;
      end

      ST_HALT: begin
        w_pc_d1_nxt      = r_pc;
        w_inst_valid_nxt = 1'b0;
      end

      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_BOOT;
      r_pc         <= RESET_ADDR;
      r_pc_d1      <= 32'd0;
      r_inst_valid <= 1'b0;
      r_trap       <= 1'b0;
      r_badaddr    <= 32'd0;
      r_count      <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_pc_d1      <= w_pc_d1_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_trap       <= w_trap_nxt;
      r_badaddr    <= w_badaddr_nxt;
      r_count      <= w_count_nxt;
    end
  end

  assign pc_out       = r_pc;
  assign pc_plus4     = r_pc + 32'd4;
  assign fetch_valid  = (r_state == ST_RUN);
  assign pc_d1        = r_pc_d1;
  assign inst_valid   = r_inst_valid;
  assign trap         = r_trap;
  assign trap_badaddr = r_badaddr;
  assign halted       = (r_state == ST_HALT);
  assign fetch_count  = r_count;

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen -- self-checking bench for pc_gen.
// Directed scenarios (reset, free run, stall, redirect under stall, trap,
// halt, reset mid-run) followed by a randomized run. Every cycle all outputs
// are compared against a behavioural model of the fetch stage.
// -----------------------------------------------------------------------------
module tb_pc_gen;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] TRAP_ADDR  = 32'h0000_0100;
  localparam int unsigned IMEM_WORDS = 512;
  localparam longint unsigned MEM_BYTES = longint'(IMEM_WORDS) * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic [31:0] pc_d1;
  logic        inst_valid;
  logic        trap;
  logic [31:0] trap_badaddr;
  logic        halted;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  pc_gen #(
    .RESET_ADDR(RESET_ADDR),
    .TRAP_ADDR (TRAP_ADDR),
    .IMEM_WORDS(IMEM_WORDS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .pc_out         (pc_out),
    .pc_plus4       (pc_plus4),
    .fetch_valid    (fetch_valid),
    .pc_d1          (pc_d1),
    .inst_valid     (inst_valid),
    .trap           (trap),
    .trap_badaddr   (trap_badaddr),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: where the stage is in its life (just reset, fetching,
  // stopped) plus the values a fetch unit is expected to present.
  bit          m_just_reset;
  bit          m_stopped;
  longint unsigned m_pc;
  longint unsigned m_word_pc;
  bit          m_word_ok;
  bit          m_trap;
  longint unsigned m_bad;
  longint unsigned m_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_just_reset = 1;
    m_stopped    = 0;
    m_pc         = RESET_ADDR;
    m_word_pc    = 0;
    m_word_ok    = 0;
    m_trap       = 0;
    m_bad        = 0;
    m_count      = 0;
  endtask

  // Advance the model by one clock given the inputs seen at that edge.
  task automatic model_step(input bit r, input bit s, input bit rv, input longint unsigned t);
    longint unsigned nxt;
    if (r) begin
      model_reset();
      return;
    end
    m_trap = 0;
    if (m_just_reset || m_stopped) begin
      m_word_pc    = m_pc;
      m_word_ok    = 0;
      m_just_reset = 0;
      return;
    end
    if (rv && (t % 4 != 0)) begin
      nxt    = TRAP_ADDR;
      m_trap = 1;
      m_bad  = t;
    end else if (rv) nxt = t;
    else if (s)      nxt = m_pc;
    else             nxt = (m_pc + 4) % (64'd1 << 32);
    if (!s || rv) begin
      m_word_pc = m_pc;
      m_word_ok = !rv;
    end
    if (!s) m_count = (m_count + 1) % (64'd1 << 32);
    m_pc = nxt;
    if (nxt >= MEM_BYTES) m_stopped = 1;
  endtask

  task automatic compare_all();
    check("pc_out",       pc_out,       32'(m_pc));
    check("pc_plus4",     pc_plus4,     32'((m_pc + 4) % (64'd1 << 32)));
    check("fetch_valid",  32'(fetch_valid), 32'(!m_just_reset && !m_stopped));
    check("inst_valid",   32'(inst_valid),  32'(m_word_ok));
    if (m_word_ok) check("pc_d1", pc_d1, 32'(m_word_pc));
    check("trap",         32'(trap),    32'(m_trap));
    check("trap_badaddr", trap_badaddr, 32'(m_bad));
    check("halted",       32'(halted),  32'(m_stopped));
    check("fetch_count",  fetch_count,  32'(m_count));
  endtask

  // Apply inputs, clock once, then compare outputs 1 time unit after the edge.
  task automatic step(input bit r, input bit s, input bit rv, input logic [31:0] t);
    rst             = r;
    stall           = s;
    redirect_valid  = rv;
    redirect_target = t;
    @(posedge clk);
    #1;
    model_step(r, s, rv, longint'(t));
    compare_all();
  endtask

  initial begin
    logic [31:0] tgt;
    bit          r_in, s_in, rv_in;

    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
    model_reset();

    // Reset, then boot cycle, then sequential fetch.
    step(1, 0, 0, 0);
    check("reset_pc",    pc_out, RESET_ADDR);
    check("reset_count", fetch_count, 32'd0);
    step(0, 0, 0, 0);
    check("boot_pc_held", pc_out, 32'h0);
    step(0, 0, 0, 0);
    check("first_word_pc", pc_d1, 32'h0);
    check("first_word_valid", 32'(inst_valid), 32'd1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("seq_pc_c", pc_out, 32'h0C);
    step(0, 0, 0, 0);
    check("at_0x10", pc_out, 32'h10);

    // Stall three cycles at 0x10: everything frozen.
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      check("stall_pc",    pc_out, 32'h10);
      check("stall_word",  pc_d1, 32'h0C);
      check("stall_count", fetch_count, 32'd4);
    end

    // Run to 0x20, then redirect to 0x40 while stalled.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    check("at_0x20", pc_out, 32'h20);
    step(0, 1, 1, 32'h40);
    check("redir_pc",    pc_out, 32'h40);
    check("redir_flush", 32'(inst_valid), 32'd0);
    step(0, 0, 0, 0);
    check("after_redir", pc_out, 32'h44);

    // Misaligned redirect traps.
    step(0, 0, 1, 32'h42);
    check("trap_pc",    pc_out, 32'h100);
    check("trap_pulse", 32'(trap), 32'd1);
    check("trap_bad",   trap_badaddr, 32'h42);
    step(0, 0, 0, 0);
    check("trap_gone",  32'(trap), 32'd0);
    check("bad_held",   trap_badaddr, 32'h42);

    // Redirect to the last word, then run off the end.
    step(0, 0, 1, 32'h7FC);
    step(0, 0, 0, 0);
    check("halt_pc",  pc_out, 32'h800);
    check("halt_set", 32'(halted), 32'd1);
    check("halt_nofetch", 32'(fetch_valid), 32'd0);
    step(0, 1, 1, 32'h40);
    step(0, 0, 1, 32'h43);
    step(0, 0, 0, 0);
    check("halt_sticky", pc_out, 32'h800);

    // Reset mid-run at 0x30 while a redirect is presented.
    step(1, 0, 0, 0);
    for (int i = 0; i < 13; i++) step(0, 0, 0, 0);
    check("at_0x30", pc_out, 32'h30);
    step(1, 0, 1, 32'h80);
    check("midrst_pc",    pc_out, RESET_ADDR);
    check("midrst_fv",    32'(fetch_valid), 32'd0);
    check("midrst_count", fetch_count, 32'd0);
    check("midrst_halt",  32'(halted), 32'd0);

    // Randomized run against the model.
    for (int i = 0; i < 2000; i++) begin
      r_in  = ($urandom_range(0, 99) < 2);
      s_in  = ($urandom_range(0, 99) < 25);
      rv_in = ($urandom_range(0, 99) < 15);
      case ($urandom_range(0, 9))
        0:       tgt = $urandom_range(0, 32'h8FF);
        1:       tgt = $urandom;
        default: tgt = $urandom_range(0, 32'h8FF) & 32'hFFFF_FFFC;
      endcase
      step(r_in, s_in, rv_in, tgt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
